// File: rtl/rf_pkg.sv
// Shared definitions for the RF command-word path.
// Holds the single-word command codes recognised by both this source and the
// RF controller, the word width, and the byte assembler state type.
package rf_pkg;

  localparam int WORD_W = 16;

  // Commands that are complete in one word (no trailing data word).
  localparam logic [WORD_W-1:0] WAIT_WORD = 16'hFFFF;
  localparam logic [WORD_W-1:0] HALT_WORD = 16'hFFF0;

  typedef enum logic {
    HI_WAIT = 1'b0,
    LO_WAIT = 1'b1
  } asm_state_t;

endpackage

// File: rtl/rf_word_fifo.sv
// Word FIFO for the RF command path.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push/wdata : write request and word
//   pop        : read request (ignored when empty)
//   clr        : discard all contents (priority over push/pop)
//   rdata      : head word, 0 when empty
//   count      : words held, 0..DEPTH
//   full/empty : derived from count
// A push while full is accepted only when a pop happens in the same cycle.
module rf_word_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clr,
  input  logic [WORD_W-1:0]       wdata,
  output logic [WORD_W-1:0]       rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]       count_q,  count_d;
  logic              do_pop, do_push;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // A pop frees the head slot first, so a full FIFO can still take a word
  // in the same cycle.
  assign do_pop  = pop && !empty && !clr && !rst;
  assign do_push = push && (!full || do_pop) && !clr && !rst;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; rdata is masked by empty instead.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/rf_word_source.sv
// Transmitter side of the RF controller's 16-bit command-word interface.
// Assembles big-endian words from UART bytes, buffers them, and presents the
// head word with a ready level.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   byte_in/valid    : UART byte and its one-cycle strobe
//   inc              : advance request, acted on at its rising edge
//   flush            : one-cycle strobe discarding all buffered data
//   data_out         : head word (0 when empty)
//   ready            : a complete command sits at the head
//   intr             : one-cycle abort pulse (flush or dropped word)
//   count            : words held
//   overflow         : sticky, a word was dropped on a full FIFO
module rf_word_source
  import rf_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 5000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  input  logic                    inc,
  input  logic                    flush,
  output logic [WORD_W-1:0]       data_out,
  output logic                    ready,
  output logic                    intr,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  asm_state_t        state_q, state_d;
  logic [7:0]        hi_q;
  logic [TW-1:0]     timer_q, timer_d;
  logic              inc_prev_q;
  logic              intr_q, intr_d;
  logic              overflow_q, overflow_d;

  logic              latch_hi, push_req, timer_inc;
  logic              pop_req, drop;
  logic              fifo_full, fifo_empty;

  // Assembler: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= HI_WAIT;
    else     state_q <= state_d;
  end

  // Assembler: next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = HI_WAIT;
    end else begin
      case (state_q)
        HI_WAIT: if (byte_valid) state_d = LO_WAIT;
        LO_WAIT: begin
          // A byte arriving on the last allowed cycle still completes the word.
          if (byte_valid)           state_d = HI_WAIT;
          else if (timer_q == TMAX) state_d = HI_WAIT;
        end
        default: state_d = HI_WAIT;
      endcase
    end
  end

  // Assembler: outputs
  always_comb begin
    latch_hi  = 1'b0;
    push_req  = 1'b0;
    timer_inc = 1'b0;
    if (!flush) begin
      case (state_q)
        HI_WAIT: latch_hi  = byte_valid;
        LO_WAIT: begin
          push_req  = byte_valid;
          timer_inc = !byte_valid && (timer_q != TMAX);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (latch_hi)       timer_d = '0;
    else if (timer_inc) timer_d = timer_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end

  always_ff @(posedge clk) begin
    if (latch_hi) hi_q <= byte_in;
  end

  // Only the rising edge of inc pops; flush overrides it.
  assign pop_req = inc && !inc_prev_q && !flush;
  // Full and no pop means the new word has nowhere to go.
  assign drop    = push_req && fifo_full && !pop_req;

  always_comb begin
    overflow_d = overflow_q;
    intr_d     = 1'b0;
    if (flush) begin
      overflow_d = 1'b0;
      intr_d     = 1'b1;
    end else if (drop) begin
      overflow_d = 1'b1;
      intr_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_prev_q <= 1'b0;
      intr_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      inc_prev_q <= inc;
      intr_q     <= intr_d;
      overflow_q <= overflow_d;
    end
  end

  rf_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop_req),
    .clr   (flush),
    .wdata ({hi_q, byte_in}),
    .rdata (data_out),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // WAIT/HALT stand alone; anything else needs its data word behind it.
  assign ready = (!fifo_empty && (data_out == WAIT_WORD || data_out == HALT_WORD))
              || (count > CNT_W'(1));

  assign intr     = intr_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_rf_word_source.sv
module tb_rf_word_source;
  import rf_pkg::*;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        rst, byte_valid, inc, flush;
  logic [7:0]  byte_in;
  logic [15:0] data_out;
  logic        ready, intr, overflow;
  logic [4:0]  count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  rf_word_source #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .inc        (inc),
    .flush      (flush),
    .data_out   (data_out),
    .ready      (ready),
    .intr       (intr),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue of words plus the pending high byte and its age.
  logic [15:0] q[$];
  bit          have_hi = 0;
  logic [7:0]  hi_b    = '0;
  int          since   = 0;
  bit          m_ovf   = 0;
  bit          m_intr  = 0;
  bit          m_incp  = 0;

  function automatic void model_update();
    bit rise, push;
    logic [15:0] w;
    w = '0;
    if (rst) begin
      q.delete(); have_hi = 0; m_ovf = 0; m_intr = 0; m_incp = 0;
      return;
    end
    rise   = inc && !m_incp;
    m_incp = inc;
    m_intr = 0;
    if (flush) begin
      q.delete(); have_hi = 0; m_ovf = 0; m_intr = 1;
      return;
    end
    push = 0;
    // Low byte must arrive no more than TIMEOUT cycles after the high byte.
    if (have_hi) begin
      since++;
      if (since > TIMEOUT) have_hi = 0;
    end
    if (byte_valid) begin
      if (have_hi) begin
        w = {hi_b, byte_in}; push = 1; have_hi = 0;
      end else begin
        hi_b = byte_in; have_hi = 1; since = 0;
      end
    end
    if (rise && q.size() > 0) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(w);
      else begin m_ovf = 1; m_intr = 1; end
    end
  endfunction

  function automatic logic [15:0] exp_head();
    return (q.size() > 0) ? q[0] : 16'h0000;
  endfunction

  function automatic logic exp_ready();
    logic [15:0] h;
    h = exp_head();
    return (q.size() >= 2) || (q.size() >= 1 && (h == 16'hFFFF || h == 16'hFFF0));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    chk("count",    32'(count),    32'(q.size()));
    chk("data_out", 32'(data_out), 32'(exp_head()));
    chk("ready",    32'(ready),    32'(exp_ready()));
    chk("intr",     32'(intr),     32'(m_intr));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_update();
    #1;
    compare();
  endtask

  task automatic send(input logic [7:0] b);
    byte_in = b; byte_valid = 1'b1;
    step();
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_inc();
    inc = 1'b1; step();
    inc = 1'b0; step();
  endtask

  initial begin
    int mode;
    rst = 1'b1; byte_valid = 1'b0; inc = 1'b0; flush = 1'b0; byte_in = '0;
    idle(2);
    rst = 1'b0;
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    idle(2);

    // Address + data word
    send(8'h81); send(8'h23); send(8'h00); send(8'h5A);
    chk("t1_count", 32'(count), 32'd2);
    chk("t1_head", 32'(data_out), 32'h8123);
    chk("t1_ready", 32'(ready), 32'd1);
    pulse_inc();
    chk("t1_pop_head", 32'(data_out), 32'h005A);
    chk("t1_pop_ready", 32'(ready), 32'd0);
    pulse_inc();
    chk("t1_empty", 32'(count), 32'd0);

    // Single-word WAIT command, inc held high
    send(8'hFF); send(8'hFF);
    chk("t2_count", 32'(count), 32'd1);
    chk("t2_ready", 32'(ready), 32'd1);
    chk("t2_head", 32'(data_out), 32'hFFFF);
    inc = 1'b1; idle(5); inc = 1'b0; step();
    chk("t2_count_after", 32'(count), 32'd0);
    chk("t2_head_after", 32'(data_out), 32'h0);

    // Timeout resync
    send(8'h12); idle(TIMEOUT); send(8'h34); send(8'h56);
    chk("t3_count", 32'(count), 32'd1);
    chk("t3_head", 32'(data_out), 32'h3456);
    pulse_inc();

    // Overflow, then full + simultaneous push/pop
    for (int i = 0; i < 17; i++) begin
      send(8'h01); send(8'(i));
    end
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_intr", 32'(intr), 32'd1);
    chk("t4_count", 32'(count), 32'd16);
    chk("t4_head", 32'(data_out), 32'h0100);
    step();
    chk("t4_intr_gone", 32'(intr), 32'd0);
    send(8'hAA);
    byte_in = 8'hBB; byte_valid = 1'b1; inc = 1'b1; step();
    byte_valid = 1'b0; inc = 1'b0;
    chk("t4_full_count", 32'(count), 32'd16);
    chk("t4_full_head", 32'(data_out), 32'h0101);
    step();
    for (int i = 0; i < 15; i++) pulse_inc();
    chk("t4_tail_word", 32'(data_out), 32'hAABB);
    pulse_inc();

    // Flush with data and a latched high byte
    for (int i = 0; i < 5; i++) begin
      send(8'h20); send(8'(i));
    end
    send(8'h99);
    flush = 1'b1; step(); flush = 1'b0;
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_ready", 32'(ready), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    chk("t5_intr", 32'(intr), 32'd1);
    send(8'hAB); send(8'hCD);
    chk("t5_head", 32'(data_out), 32'hABCD);

    // Reset mid-stream
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_data", 32'(data_out), 32'h0);
    send(8'h77); send(8'h88);
    chk("t6_head", 32'(data_out), 32'h7788);
    chk("t6_count2", 32'(count), 32'd1);

    // Randomized traffic
    for (int blk = 0; blk < 80; blk++) begin
      mode = $urandom_range(0, 2);
      for (int c = 0; c < 50; c++) begin
        rst   = ($urandom_range(0, 599) == 0);
        flush = ($urandom_range(0, 199) == 0);
        case (mode)
          0:       byte_valid = ($urandom_range(0, 1) == 1);
          1:       byte_valid = ($urandom_range(0, 13) == 0);
          default: byte_valid = ($urandom_range(0, 3) != 0);
        endcase
        case ($urandom_range(0, 3))
          0:       byte_in = 8'hFF;
          1:       byte_in = 8'hF0;
          default: byte_in = 8'($urandom);
        endcase
        inc = (mode == 2) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
        step();
      end
    end
    rst = 1'b0; flush = 1'b0; byte_valid = 1'b0; inc = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_word_source.md
# rf_word_source

Transmitter side of the RF controller's 16-bit command-word interface. Assembles bytes from the PC link into big-endian 16-bit words, buffers them in a FIFO, and presents the head word on `data_out` with a `ready` level. The RF controller consumes words by pulsing `inc`. The block sits between the UART byte receiver and the RF controller, and drives the controller's `data_in`, `ready` and `intr` inputs.

## Interface
- `DEPTH`, default 16: FIFO depth in words; power of two, at least 4.
- `TIMEOUT`, default 5000: clocks allowed between the high and low byte of a word before the high byte is discarded.
- `clk` input 1: system clock.
- `rst` input 1: reset. Synchronous, active-high, sampled on the rising edge of `clk`.
- `byte_in` input 8: byte from the UART receiver.
- `byte_valid` input 1: one-cycle strobe qualifying `byte_in`.
- `inc` input 1: advance request from the RF controller. Only its rising edge is acted on.
- `flush` input 1: one-cycle strobe that discards all buffered data.
- `data_out` output 16: FIFO head word; 16'h0000 when the FIFO is empty.
- `ready` output 1: a complete command is available at the head.
- `intr` output 1: one-cycle abort pulse to the RF controller.
- `count` output $clog2(DEPTH)+1: number of words held.
- `overflow` output 1: sticky flag; set when a word is dropped because the FIFO was full.

## Operation
- Byte assembler state machine:
  - `HI_WAIT`: on `byte_valid`, latch `byte_in` as `hi`, clear the timer, go to `LO_WAIT`.
  - `LO_WAIT`: on `byte_valid`, push `{hi, byte_in}` and go to `HI_WAIT`. Otherwise the timer increments. When the timer reaches `TIMEOUT-1` with no byte, drop `hi` and return to `HI_WAIT` (resync). No word is pushed on a timeout.
- Pop rule: `inc_prev` is registered every cycle. A pop occurs when `inc && !inc_prev` and `count != 0`. A rising edge of `inc` with an empty FIFO is ignored.
- `ready` is derived from the registered state:
  - 1 when the head word is `WAIT_WORD` (16'hFFFF) or `HALT_WORD` (16'hFFF0) and `count >= 1`. These are single-word commands.
  - 1 otherwise when `count >= 2` (address word plus data word).
  - 0 in all other cases.
- Push and pop in the same cycle: both occur and `count` is unchanged. This holds even when the FIFO is full, because the pop frees the slot first.
- Push while full without a simultaneous pop: the word is dropped, `overflow` is set, and `intr` pulses for one cycle.
- `flush`:
  - Next cycle: `count = 0`, read and write pointers = 0, assembler in `HI_WAIT`, `overflow = 0`, `intr = 1` for one cycle.
  - `flush` has priority over any push or pop in the same cycle.
- Pointers wrap modulo `DEPTH`. `count` ranges 0..`DEPTH`.

## Timing
- Values after `rst`:
  - `data_out` = 0, `ready` = 0, `intr` = 0, `count` = 0, `overflow` = 0.
  - Assembler in `HI_WAIT`, `inc_prev` = 0.
  - `rst` dominates `flush`, `byte_valid` and `inc` in the same cycle.
- Push latency: the low byte's `byte_valid` at cycle N updates `count`, `data_out` (if the FIFO was empty) and `ready` at cycle N+1.
- Pop latency: the `inc` rising edge sampled at cycle N advances the head; the new `data_out` and `ready` are visible at N+1.
- `inc` held high for several cycles produces exactly one pop.
- `intr` is a registered pulse exactly one cycle wide. Overflow and `flush` in the same cycle still give a single pulse.
- Reset asserted mid-word discards the partial `hi` byte.

## Structure
- Shared package `rf_pkg` holds:
  - `WAIT_WORD` = 16'hFFFF and `HALT_WORD` = 16'hFFF0, also used by the RF controller.
  - Assembler state typedef `asm_state_t {HI_WAIT, LO_WAIT}`.
- Sub-module `rf_word_fifo`:
  - Parameterised by `DEPTH`.
  - Ports: `push`, `pop`, `clr`, `wdata`, `rdata` (head), `count`, `full`, `empty`.
  - Handles simultaneous push/pop, and full/empty by `count`.
- The top level contains the assembler, timeout counter, `inc` edge detect, `ready` logic, `overflow` and `intr`.

## Test plan
- Bytes 0x81, 0x23, 0x00, 0x5A (command word plus data word) → after the fourth byte, `count` = 2, `data_out` = 16'h8123, `ready` = 1. One `inc` pulse → `data_out` = 16'h005A, `ready` = 0.
- Byte 0xFF then 0xFF with an empty FIFO → `count` = 1, `ready` = 1, `data_out` = 16'hFFFF. `inc` held high for 5 cycles → exactly one pop, `count` = 0, `data_out` = 0.
- Byte 0x12, then idle for `TIMEOUT` cycles, then 0x34, 0x56 → a single word 16'h3456 is pushed; no word contains 0x12.
- Push 17 words with `DEPTH` = 16 → the 17th is dropped, `overflow` = 1, one-cycle `intr`, `count` = 16, head = first word. Then the FIFO is full, the last byte of a word arrives and `inc` rises in the same cycle → `count` stays 16 and the new word is stored.
- `flush` with `count` = 5 and `hi` latched → next cycle `count` = 0, `ready` = 0, `overflow` = 0, `intr` pulse. The following byte is treated as a high byte.
- `rst` asserted for 1 cycle mid-stream with `count` = 3 → all outputs are 0 next cycle; a later 2-byte word is assembled correctly.
